// File: rtl/four_bit_operand_loader.sv
// Serial-to-parallel loader for the XOR stage operands.
// Assembles A then B from a bit stream and presents them as a pair.
module four_bit_operand_loader #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [7:0]       pair_count
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    PRESENT
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sr_a, sr_a_n;
  logic [WIDTH-1:0] sr_b, sr_b_n;
  logic [WIDTH-1:0] a_n, b_n;
  logic             v_n;
  logic [7:0]       pc_n;
  logic             take;
  logic             last;

  function automatic logic [WIDTH-1:0] shift_in(
    input logic [WIDTH-1:0] sr,
    input logic             b
  );
    if (MSB_FIRST)
      return {sr[WIDTH-2:0], b};
    else
      return {b, sr[WIDTH-1:1]};
  endfunction

  assign bit_ready = (state != PRESENT);
  assign take      = bit_valid && bit_ready;
  assign last      = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_a_n  = sr_a;
    sr_b_n  = sr_b;
    a_n     = a_out;
    b_n     = b_out;
    v_n     = op_valid;
    pc_n    = pair_count;
    unique case (state)
      LOAD_A: begin
        if (take) begin
          sr_a_n = shift_in(sr_a, bit_in);
          if (last) begin
            cnt_n   = '0;
            state_n = LOAD_B;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      LOAD_B: begin
        if (take) begin
          sr_b_n = shift_in(sr_b, bit_in);
          if (last) begin
            cnt_n   = '0;
            state_n = PRESENT;
            a_n     = sr_a;
            b_n     = sr_b_n;
            v_n     = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      PRESENT: begin
        if (op_ready) begin
          v_n     = 1'b0;
          pc_n    = pair_count + 8'd1;
          state_n = LOAD_A;
        end
      end
      default: state_n = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD_A;
      cnt        <= '0;
      sr_a       <= '0;
      sr_b       <= '0;
      a_out      <= '0;
      b_out      <= '0;
      op_valid   <= 1'b0;
      pair_count <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sr_a       <= sr_a_n;
      sr_b       <= sr_b_n;
      a_out      <= a_n;
      b_out      <= b_n;
      op_valid   <= v_n;
      pair_count <= pc_n;
    end
  end

endmodule

// File: tb/tb_four_bit_operand_loader.sv
// Bench for four_bit_operand_loader: MSB-first and LSB-first
// instances share one stream; a scoreboard holds expected pairs.
module tb_four_bit_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       op_ready;
  logic       bit_ready0, bit_ready1;
  logic [3:0] a_out0, b_out0, a_out1, b_out1;
  logic       op_valid0, op_valid1;
  logic [7:0] pair_count0, pair_count1;

  int n_cmp = 0;
  int n_err = 0;
  logic        mon_on = 1'b0;
  logic        prev_v = 1'b0;
  logic [15:0] sb[$];
  logic [7:0]  exp_cnt = 8'd0;
  logic [3:0]  last_a = 4'h0;
  logic [3:0]  last_b = 4'h0;

  always #5 clk = ~clk;

  four_bit_operand_loader #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready0), .a_out(a_out0), .b_out(b_out0),
    .op_valid(op_valid0), .op_ready(op_ready),
    .pair_count(pair_count0)
  );

  four_bit_operand_loader #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready1), .a_out(a_out1), .b_out(b_out1),
    .op_valid(op_valid1), .op_ready(op_ready),
    .pair_count(pair_count1)
  );

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [3:0] a, input logic [3:0] b,
                           input int gmax);
    logic [7:0] s;
    int g;
    s = {a, b};
    sb.push_back({a, b, rev4(a), rev4(b)});
    last_a = a;
    last_b = b;
    for (int i = 7; i >= 0; i--) begin
      g = (gmax > 0) ? int'($urandom_range(gmax, 1)) : 0;
      repeat (g) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom_range(1, 0));
        tick();
      end
      bit_valid = 1'b1;
      bit_in    = s[i];
      tick();
      bit_valid = 1'b0;
    end
    check("op_valid_rise", 16'(op_valid0), 16'd1);
  endtask

  task automatic consume();
    int n;
    n = 0;
    while (!op_valid0 && n < 50) begin
      tick();
      n++;
    end
    if (!op_valid0) check("op_valid_timeout", 16'(op_valid0), 16'd1);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    exp_cnt++;
    check("op_valid_drop", 16'(op_valid0), 16'd0);
    check("pair_count0", 16'(pair_count0), 16'(exp_cnt));
    check("pair_count1", 16'(pair_count1), 16'(exp_cnt));
    check("a_hold", 16'(a_out0), 16'(last_a));
    check("b_hold", 16'(b_out0), 16'(last_b));
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      logic [15:0] e;
      check("bit_ready0", 16'(bit_ready0), 16'(!op_valid0));
      check("bit_ready1", 16'(bit_ready1), 16'(!op_valid1));
      check("valid_match", 16'(op_valid1), 16'(op_valid0));
      if (op_valid0 && !prev_v) begin
        if (sb.size() == 0) begin
          check("sb_empty", 16'd1, 16'd0);
        end else begin
          e = sb.pop_front();
          check("a_msb", 16'(a_out0), 16'(e[15:12]));
          check("b_msb", 16'(b_out0), 16'(e[11:8]));
          check("a_lsb", 16'(a_out1), 16'(e[7:4]));
          check("b_lsb", 16'(b_out1), 16'(e[3:0]));
          check("xor", 16'(a_out0 ^ b_out0), 16'(e[15:12] ^ e[11:8]));
        end
      end
      prev_v <= op_valid0;
    end
  end

  initial begin
    rst       = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    op_ready  = 1'b0;
    tick();
    tick();
    check("rst_a", 16'(a_out0), 16'd0);
    check("rst_b", 16'(b_out0), 16'd0);
    check("rst_valid", 16'(op_valid0), 16'd0);
    check("rst_count", 16'(pair_count0), 16'd0);
    check("rst_ready", 16'(bit_ready0), 16'd1);
    rst    = 1'b0;
    mon_on = 1'b1;
    tick();

    send_pair(4'h3, 4'h5, 0);
    check("xor_3_5", 16'(a_out0 ^ b_out0), 16'h6);
    consume();

    send_pair(4'hC, 4'hA, 0);
    check("lsb_a", 16'(a_out1), 16'h3);
    check("lsb_b", 16'(b_out1), 16'h5);
    consume();

    send_pair(4'h9, 4'h6, 0);
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      bit_in    = i[0];
      tick();
      check("bp_valid", 16'(op_valid0), 16'd1);
      check("bp_ready", 16'(bit_ready0), 16'd0);
      check("bp_a", 16'(a_out0), 16'h9);
      check("bp_b", 16'(b_out0), 16'h6);
    end
    bit_valid = 1'b0;
    consume();
    send_pair(4'h1, 4'h8, 0);
    consume();

    send_pair(4'hA, 4'hF, 3);
    consume();

    for (int i = 0; i < 6; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    exp_cnt   = 8'd0;
    check("mid_rst_valid", 16'(op_valid0), 16'd0);
    check("mid_rst_a", 16'(a_out0), 16'd0);
    check("mid_rst_b", 16'(b_out0), 16'd0);
    check("mid_rst_ready", 16'(bit_ready0), 16'd1);
    check("mid_rst_count", 16'(pair_count0), 16'd0);
    send_pair(4'h2, 4'h7, 0);
    consume();

    for (int i = 1; i < 256; i++) begin
      send_pair(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                (i % 17 == 0) ? 2 : 0);
      consume();
    end
    check("wrap_count", 16'(pair_count0), 16'd0);
    check("sb_drained", 16'(sb.size()), 16'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
